// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types and step/word helpers (LFSR_LEN < 64, word width < 256)
package lfsr_pkg;

    localparam int STATE_MAX = 64;
    localparam int WORD_MAX  = 256;

    typedef enum logic [0:0] {IDLE, RUN} fsm_state_e;

    typedef struct packed {
        logic [WORD_MAX-1:0]  word;
        logic [STATE_MAX-1:0] state;
    } lfsr_word_t;

    function automatic logic [STATE_MAX-1:0] lfsr_step(input logic [STATE_MAX-1:0] state,
                                                        input logic [STATE_MAX-1:0] poly,
                                                        input int len);
        logic [STATE_MAX-1:0] one;
        logic [STATE_MAX-1:0] mask;
        logic                 nb;
        one  = {{(STATE_MAX-1){1'b0}}, 1'b1};
        mask = (one << len) - one;
        nb   = ^(state & poly);
        return ((state << 1) | {{(STATE_MAX-1){1'b0}}, nb}) & mask;
    endfunction

    // First feedback bit lands in word[dw-1], last in word[0].
    function automatic lfsr_word_t lfsr_word(input logic [STATE_MAX-1:0] state,
                                             input logic [STATE_MAX-1:0] poly,
                                             input int len,
                                             input int dw);
        lfsr_word_t r;
        r.word  = '0;
        r.state = state;
        for (int i = 0; i < WORD_MAX; i++) begin
            if (i < dw) begin
                r.word  = {r.word[WORD_MAX-2:0], ^(r.state & poly)};
                r.state = lfsr_step(r.state, poly, len);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// rtl/lfsr_step_n.sv - combinational N-step Fibonacci LFSR advance producing one N-bit word
module lfsr_step_n
    import lfsr_pkg::*;
#(
    parameter int                  N         = 32,
    parameter int                  LFSR_LEN  = 15,
    parameter logic [LFSR_LEN-1:0] LFSR_POLY = 15'h6000
) (
    input  logic [LFSR_LEN-1:0] state_i,
    output logic [N-1:0]        word_o,
    output logic [LFSR_LEN-1:0] state_o
);

    logic [STATE_MAX-1:0] state_pad;
    logic [STATE_MAX-1:0] poly_pad;
    lfsr_word_t           res;
    logic                 unused_hi;

    assign state_pad = {{(STATE_MAX-LFSR_LEN){1'b0}}, state_i};
    assign poly_pad  = {{(STATE_MAX-LFSR_LEN){1'b0}}, LFSR_POLY};

    always_comb begin
        res = lfsr_word(state_pad, poly_pad, LFSR_LEN, N);
    end

    assign word_o    = res.word[N-1:0];
    assign state_o   = res.state[LFSR_LEN-1:0];
    assign unused_hi = ^{res.word[WORD_MAX-1:N], res.state[STATE_MAX-1:LFSR_LEN]};

endmodule

// File: rtl/lfsr_prbs_stream.sv
// rtl/lfsr_prbs_stream.sv - PRBS word source with burst framing; LFSR_ERR_INJECT_EN adds bit-0 error injection
module lfsr_prbs_stream
    import lfsr_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  LFSR_LEN   = 15,
    parameter logic [LFSR_LEN-1:0] LFSR_POLY  = 15'h6000,
    parameter logic [LFSR_LEN-1:0] LFSR_INIT  = {{(LFSR_LEN-1){1'b0}}, 1'b1},
    parameter int                  CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LFSR_LEN-1:0]   seed_i,
    input  logic                  seed_load_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  burst_len_i,
    input  logic                  stop_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o
`ifdef LFSR_ERR_INJECT_EN
    ,
    input  logic                  err_inject_i
`endif
);

    localparam logic [LFSR_LEN-1:0]  STATE_ONE = {{(LFSR_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_TWO   = CNT_ONE << 1;

    fsm_state_e            fsm_q;
    logic [LFSR_LEN-1:0]   state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  stop_pend_q;

    logic [LFSR_LEN-1:0]   seed_eff;
    logic [LFSR_LEN-1:0]   gen_state;
    logic [LFSR_LEN-1:0]   step_state;
    logic [DATA_WIDTH-1:0] step_word;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  handshake;
    logic                  stop_seen;
    logic                  final_word;
    logic                  word_load_en;

    // An all-zero state would lock up, so a zero seed becomes 1.
    assign seed_eff     = (seed_i == '0) ? STATE_ONE : seed_i;
    assign gen_state    = (fsm_q == IDLE && seed_load_i) ? seed_eff : state_q;
    assign handshake    = valid_q & m_ready_i;
    assign stop_seen    = stop_pend_q | stop_i;
    assign final_word   = stop_seen | (cnt_q == CNT_ONE);
    assign word_load_en = (fsm_q == IDLE && start_i) ||
                          (fsm_q == RUN && handshake && !final_word);

    lfsr_step_n #(
        .N         (DATA_WIDTH),
        .LFSR_LEN  (LFSR_LEN),
        .LFSR_POLY (LFSR_POLY)
    ) u_step (
        .state_i (gen_state),
        .word_o  (step_word),
        .state_o (step_state)
    );

`ifdef LFSR_ERR_INJECT_EN
    logic                  err_pend_q;
    logic                  err_req;
    logic [DATA_WIDTH-1:0] err_mask;

    assign err_req = err_pend_q | err_inject_i;

    always_comb begin
        err_mask    = '0;
        err_mask[0] = err_req;
    end

    assign load_word = step_word ^ err_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= err_req & ~word_load_en;
        end
    end
`else
    assign load_word = step_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= LFSR_INIT;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (seed_load_i) begin
                        state_q <= seed_eff;
                    end
                    if (start_i) begin
                        state_q <= step_state;
                        data_q  <= load_word;
                        valid_q <= 1'b1;
                        last_q  <= (burst_len_i == CNT_ONE);
                        cnt_q   <= burst_len_i;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                        if (final_word) begin
                            valid_q     <= 1'b0;
                            last_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                            fsm_q       <= IDLE;
                        end else begin
                            state_q <= step_state;
                            data_q  <= load_word;
                            last_q  <= (cnt_q == CNT_TWO);
                        end
                    end else begin
                        stop_pend_q <= stop_seen;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;
    assign busy_o    = (fsm_q == RUN);

endmodule
